// File: rtl/fan_pkg.sv
// Shared FSM state type and default parameter values for the fan tachometer meter.
package fan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } fan_state_t;

  localparam int PRESC_DEF    = 100;
  localparam int CNT_W_DEF    = 12;
  localparam int PPR_DEF      = 2;
  localparam int FILT_LEN_DEF = 4;

endpackage

// File: rtl/tach_filter.sv
// Two-flop synchronizer plus run-length glitch filter for the raw tach line;
// emits the accepted level and a one-cycle strobe when it rises.
module tach_filter
  import fan_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tach_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] RUN_LAST = FW'(FILT_LEN - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [FW-1:0] run_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      run_cnt <= '0;
      lvl_o   <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      sync_p0 <= tach_i;
      // filter stage: run_cnt counts consecutive samples that disagree with lvl_o
      sync_p1 <= sync_p0;
      rise_o  <= 1'b0;
      if (sync_p1 == lvl_o) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        lvl_o   <= sync_p1;
        rise_o  <= sync_p1;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fan_tach_meter.sv
// Fan tachometer meter: counts prescaled ticks across PPR filtered tach edges
// (one revolution) and reports the period, or all-ones plus stall on timeout.
module fan_tach_meter
  import fan_pkg::*;
#(
  parameter int PRESC    = PRESC_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PPR      = PPR_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             tach_i,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             stall_o
);

  localparam int PW = $clog2(PRESC);
  localparam int EW = $clog2(PPR + 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
  localparam logic [EW-1:0]    EDGE_LAST  = EW'(PPR - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  fan_state_t       state;
  fan_state_t       next_state;
  logic [PW-1:0]    presc_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] tick_next;
  logic [EW-1:0]    edge_cnt;
  logic             tach_lvl;
  logic             tach_rise;
  logic             edge_evt;
  logic             tick;
  logic             sat_hit;
  logic             win_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    sat_inc = (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  tach_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .tach_i(tach_i),
    .lvl_o (tach_lvl),
    .rise_o(tach_rise)
  );

  assign edge_evt = tach_rise & tach_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!en_i) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    next_state = ST_ARM;
        ST_ARM:     if (edge_evt) next_state = ST_MEASURE;
        ST_MEASURE: if (sat_hit) next_state = ST_ARM;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // A tick landing on the closing edge is folded into the latched count.
  always_comb begin
    tick      = 1'b0;
    tick_next = tick_cnt;
    sat_hit   = 1'b0;
    win_done  = 1'b0;
    if (state == ST_MEASURE && en_i) begin
      tick      = (presc_cnt == PRESC_LAST);
      tick_next = sat_inc(tick_cnt, tick);
      sat_hit   = (tick_next == CNT_MAX);
      win_done  = edge_evt && (edge_cnt == EDGE_LAST) && !sat_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
      tick_cnt  <= '0;
      edge_cnt  <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      stall_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      // window restart: next window begins in the same cycle the result is latched
      if (state != ST_MEASURE || !en_i || sat_hit || win_done) begin
        presc_cnt <= '0;
        tick_cnt  <= '0;
        edge_cnt  <= '0;
      end else begin
        presc_cnt <= (presc_cnt == PRESC_LAST) ? '0 : presc_cnt + 1'b1;
        tick_cnt  <= tick_next;
        if (edge_evt) edge_cnt <= edge_cnt + 1'b1;
      end
      if (sat_hit) begin
        period_o <= CNT_MAX;
        stall_o  <= 1'b1;
        valid_o  <= 1'b1;
      end else if (win_done) begin
        period_o <= tick_next;
        stall_o  <= 1'b0;
        valid_o  <= 1'b1;
      end else if (!en_i) begin
        stall_o  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fan_tach_meter.md
FAN_TACH_METER -- requirements
Module: fan_tach_meter

Interface
REQ-001 SHALL have parameter PRESC, default 100: clk cycles per measurement tick (>=2).
REQ-002 SHALL have parameter CNT_W, default 12: width of the tick counter and of period_o.
REQ-003 SHALL have parameter PPR, default 2: tach pulses per fan revolution (>=1).
REQ-004 SHALL have parameter FILT_LEN, default 4: consecutive equal samples needed to accept a tach level.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port en_i, input, 1: measurement enable.
REQ-008 SHALL have port tach_i, input, 1: raw asynchronous fan tachometer signal.
REQ-009 SHALL have port period_o, output, CNT_W: ticks per revolution; this is the process value fed to the PID stage.
REQ-010 SHALL have port valid_o, output, 1: one-cycle strobe marking a new period_o.
REQ-011 SHALL have port stall_o, output, 1: fan stalled or missing; level signal.

Function
REQ-012 SHALL pass tach_i through a 2-flop synchronizer, then a glitch filter that changes the filtered level only after FILT_LEN consecutive equal synchronized samples.
REQ-013 SHALL detect a rising edge of the filtered level as a one-cycle event; total latency from tach_i to the event = 2 + FILT_LEN cycles.
REQ-014 SHALL run a prescaler 0..PRESC-1 that emits a tick when it wraps from PRESC-1 to 0; the prescaler runs only in MEASURE.
REQ-015 SHALL implement an FSM with states IDLE, ARM and MEASURE.
REQ-016 IDLE: entered whenever en_i=0 (from any state, next cycle); clears prescaler, tick counter and edge counter; goes to ARM when en_i=1.
REQ-017 ARM: waits for a rising-edge event; on the event goes to MEASURE with prescaler, tick count and edge count = 0.
REQ-018 MEASURE: increments the tick counter on each tick and the edge counter on each edge event.
REQ-019 SHALL, on the PPR-th edge in MEASURE, load period_o with the tick count and pulse valid_o in the next cycle; the tick counter, prescaler and edge counter restart at 0 in that same cycle, so the next window starts with no gap.
REQ-020 SHALL, when a tick and the PPR-th edge coincide, include that tick in the latched count.
REQ-021 SHALL saturate the tick counter at 2^CNT_W-1; on reaching it, SHALL set period_o = all-ones, set stall_o=1, pulse valid_o, and return to ARM.
REQ-022 SHALL clear stall_o on the next normal valid_o pulse or on entering IDLE.
REQ-023 SHALL hold period_o at its last value while in IDLE or ARM.
REQ-024 SHALL not assert valid_o when en_i falls mid-window; a partial window is discarded.

Reset
REQ-025 rst SHALL asynchronously force period_o=0, valid_o=0, stall_o=0, FSM=IDLE, and all counters, synchronizer flops and filter state to 0.
REQ-026 After rst deasserts, the first valid_o SHALL occur only after a full ARM edge plus PPR edges.

Structure
REQ-027 The FSM state type and the default parameter constants SHALL live in shared package fan_pkg.
REQ-028 The synchronizer and glitch filter SHALL form sub-module tach_filter, which outputs the filtered level and the rising-edge event.

Verification (PRESC=4, CNT_W=8, PPR=2, FILT_LEN=2)
REQ-029 50% square wave, 40-cycle period, en_i=1 -> after the arming edge, valid_o every 80 cycles with period_o=20, stall_o=0.
REQ-030 1-cycle high glitches on tach_i with the line otherwise low -> no edge event, FSM stays in ARM, no valid_o.
REQ-031 Arm, then hold tach_i low for 1020+ cycles -> stall_o=1, period_o=255, one valid_o; restart the 40-cycle wave -> first normal valid_o shows period_o=20 and stall_o=0.
REQ-032 en_i dropped mid-window -> no valid_o, period_o unchanged; en_i re-raised -> ARM edge plus 2 edges before the next valid_o (period_o=20).
REQ-033 rst pulsed mid-window, no clk edge during the pulse -> outputs 0 immediately; afterwards normal measurement resumes per REQ-026.
